// File: rtl/video_timing_gen.sv
// video_timing_gen: ce/hsync/vsync/de timing with a 2-clk aligned RGB return path.
// Define VTG_TEST_PATTERN_EN to build the 8-bar colour pattern selected by pattern_sel.
module video_timing_gen #(
  parameter int H_ACTIVE = 160,
  parameter int H_FP     = 8,
  parameter int H_SYNC   = 16,
  parameter int H_BP     = 16,
  parameter int V_ACTIVE = 144,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 8,
  parameter int CE_DIV   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        pattern_sel,
  output logic [11:0] x,
  output logic [11:0] y,
  input  logic [23:0] rgb_in,
  output logic [23:0] dout,
  output logic        hs_out,
  output logic        vs_out,
  output logic        de_out,
  output logic        ce_out,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      CE_DIV < 1 || CE_DIV > 16 ||
      H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_param
    $error("video_timing_gen: invalid parameter set");
  end

  localparam logic [3:0]  CE_LAST = 4'(CE_DIV - 1);
  localparam logic [11:0] X_LAST  = 12'(H_TOTAL - 1);
  localparam logic [11:0] Y_LAST  = 12'(V_TOTAL - 1);
  localparam logic [11:0] X_ACT   = 12'(H_ACTIVE);
  localparam logic [11:0] Y_ACT   = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEG  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END  = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END  = 12'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic ce;
    logic fs;
  } tim_t;

  logic [3:0]  cnt_q, cnt_d;
  logic        ce_q, ce_d;
  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  tim_t        raw;
  tim_t        s1_q, s1_d;
  tim_t        s2_q, s2_d;
  logic [23:0] dout_q, dout_d;
  logic [23:0] pix;

  // ce is registered one clk behind the divider wrap; x/y step on it
  always_comb begin
    cnt_d = '0;
    ce_d  = 1'b0;
    x_d   = '0;
    y_d   = '0;
    if (enable) begin
      ce_d  = (cnt_q == CE_LAST);
      cnt_d = ce_d ? 4'd0 : cnt_q + 4'd1;
      x_d   = x_q;
      y_d   = y_q;
      if (ce_q) begin
        if (x_q == X_LAST) begin
          x_d = '0;
          y_d = (y_q == Y_LAST) ? 12'd0 : y_q + 12'd1;
        end else begin
          x_d = x_q + 12'd1;
        end
      end
    end
  end

  always_comb begin
    raw.de = (x_q < X_ACT) && (y_q < Y_ACT);
    raw.hs = (x_q >= HS_BEG) && (x_q < HS_END);
    raw.vs = (y_q >= VS_BEG) && (y_q < VS_END);
    raw.ce = ce_q;
    raw.fs = ce_q && (x_q == 12'd0) && (y_q == 12'd0);
  end

  assign s1_d   = enable ? raw  : '0;
  assign s2_d   = enable ? s1_q : '0;
  assign dout_d = (enable && s1_q.de) ? pix : 24'd0;

`ifdef VTG_TEST_PATTERN_EN
  logic [2:0]  bar_q, bar_d;
  logic        pat_q, pat_d;
  logic [14:0] x8;
  logic [23:0] bar_rgb;

  assign x8    = {x_q, 3'b000};
  assign bar_d = !enable ? 3'd0 :
                 (x_q < X_ACT) ? 3'(x8 / 15'(H_ACTIVE)) : 3'd7;
  assign pat_d = enable && pattern_sel;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bar_q <= '0;
      pat_q <= 1'b0;
    end else begin
      bar_q <= bar_d;
      pat_q <= pat_d;
    end
  end

  always_comb begin
    bar_rgb = 24'h000000;
    unique case (bar_q)
      3'd0: bar_rgb = 24'hFFFFFF;
      3'd1: bar_rgb = 24'hFFFF00;
      3'd2: bar_rgb = 24'h00FFFF;
      3'd3: bar_rgb = 24'h00FF00;
      3'd4: bar_rgb = 24'hFF00FF;
      3'd5: bar_rgb = 24'hFF0000;
      3'd6: bar_rgb = 24'h0000FF;
      3'd7: bar_rgb = 24'h000000;
    endcase
  end

  assign pix = pat_q ? bar_rgb : rgb_in;
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = pattern_sel;
  assign pix = rgb_in;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      ce_q   <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      dout_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      ce_q   <= ce_d;
      x_q    <= x_d;
      y_q    <= y_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      dout_q <= dout_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign dout        = dout_q;
  assign hs_out      = s2_q.hs;
  assign vs_out      = s2_q.vs;
  assign de_out      = s2_q.de;
  assign ce_out      = s2_q.ce;
  assign frame_start = s2_q.fs;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: scoreboard bench, small raster (16x8), CE_DIV=2 and CE_DIV=1.
// Expected outputs come from a closed-form model of clocks-since-enable.
module tb_video_timing_gen;

  typedef struct packed {
    logic [23:0] d;
    logic hs;
    logic vs;
    logic de;
    logic ce;
    logic fs;
  } vo_t;

`ifdef VTG_TEST_PATTERN_EN
  localparam bit BARS = 1'b1;
`else
  localparam bit BARS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic pattern_sel = 1'b0;
  logic [23:0] rgb0 = '0, rgb1 = '0;
  logic [11:0] x0, y0, x1, y1;
  logic [23:0] dout0, dout1;
  logic hs0, vs0, de0, ce0, fs0;
  logic hs1, vs1, de1, ce1, fs1;
  vo_t g0, g1;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign g0 = {dout0, hs0, vs0, de0, ce0, fs0};
  assign g1 = {dout1, hs1, vs1, de1, ce1, fs1};

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2), .CE_DIV(2)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .pattern_sel(pattern_sel), .x(x0), .y(y0), .rgb_in(rgb0),
    .dout(dout0), .hs_out(hs0), .vs_out(vs0), .de_out(de0),
    .ce_out(ce0), .frame_start(fs0)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2), .CE_DIV(1)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .pattern_sel(pattern_sel), .x(x1), .y(y1), .rgb_in(rgb1),
    .dout(dout1), .hs_out(hs1), .vs_out(vs1), .de_out(de1),
    .ce_out(ce1), .frame_start(fs1)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pix_of(int k, int d);
    return (k == 0) ? 0 : (k - 1) / d;
  endfunction

  function automatic logic [23:0] colour(int xx, int yy, bit pat);
    logic [7:0] xb, yb;
    xb = 8'(xx);
    yb = 8'(yy);
    if (BARS && pat) begin
      case (xx)
        0: return 24'hFFFFFF;
        1: return 24'hFFFF00;
        2: return 24'h00FFFF;
        3: return 24'h00FF00;
        4: return 24'hFF00FF;
        5: return 24'hFF0000;
        6: return 24'h0000FF;
        default: return 24'h000000;
      endcase
    end
    return {xb, yb, 8'hA5};
  endfunction

  function automatic vo_t model(int k, int d, bit pat);
    int p, xx, yy;
    vo_t r;
    p = pix_of(k, d);
    xx = p % 16;
    yy = (p / 16) % 8;
    r.ce = (k != 0) && (k % d == 0);
    r.de = (xx < 8) && (yy < 4);
    r.hs = (xx >= 10) && (xx < 12);
    r.vs = (yy == 5);
    r.fs = r.ce && (xx == 0) && (yy == 0);
    r.d  = r.de ? colour(xx, yy, pat) : 24'h0;
    return r;
  endfunction

  function automatic logic [23:0] model_xy(int k, int d);
    int p;
    p = pix_of(k, d);
    return {12'(p % 16), 12'((p / 16) % 8)};
  endfunction

  // rgb_in returns the pixel for the x/y seen during the previous clk
  logic [15:0] s0, s1;
  initial forever begin
    @(negedge clk);
    s0 = {x0[7:0], y0[7:0]};
    s1 = {x1[7:0], y1[7:0]};
    @(posedge clk);
    #1;
    rgb0 = {s0, 8'hA5};
    rgb1 = {s1, 8'hA5};
  end

  vo_t q0[$], q1[$];
  vo_t e0, e1;
  int k0 = 0, k1 = 0;
  logic en_s, pat_s;

  initial forever begin
    @(posedge clk);
    en_s  = enable && reset_n;
    pat_s = pattern_sel;
    #1;
    if (!en_s) begin
      k0 = 0;
      e0 = '0;
      q0.delete();
      k1 = 0;
      e1 = '0;
      q1.delete();
    end else begin
      k0++;
      k1++;
      e0 = (q0.size() >= 2) ? q0.pop_front() : '0;
      e1 = (q1.size() >= 2) ? q1.pop_front() : '0;
    end
    q0.push_back(model(k0, 2, pat_s));
    q1.push_back(model(k1, 1, pat_s));
    chk("sb0_out", 64'(g0), 64'(e0));
    chk("sb0_xy", 64'({x0, y0}), 64'(model_xy(k0, 2)));
    chk("sb1_out", 64'(g1), 64'(e1));
    chk("sb1_xy", 64'({x1, y1}), 64'(model_xy(k1, 1)));
  end

  task automatic first_ce(input string tag);
    int lat;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) chk({tag, "_restart_xy"}, 64'({x0, y0}), 64'd0);
      if (ce0) begin
        lat = i;
        break;
      end
    end
    chk({tag, "_first_ce_lat"}, 64'(lat), 64'd4);
    chk({tag, "_first_fs"}, 64'(fs0), 64'd1);
  endtask

  task automatic wait_xy(input int wx, input int wy, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      if (x0 == 12'(wx) && y0 == 12'(wy)) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 64'(ok), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_ce, n_dep, n_hs, n_vs, n_fs, fs_a, fs_b, n_bad;
    int n_ce1, n_fs1, n_hs1;
    logic [23:0] px[8];
    int np;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out0", 64'(g0), 64'd0);
    chk("rst_out1", 64'(g1), 64'd0);
    chk("rst_xy0", 64'({x0, y0}), 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b1;
    first_ce("s1");

    n_ce = 0; n_dep = 0; n_hs = 0; n_vs = 0; n_fs = 0;
    fs_a = 0; fs_b = 0; n_bad = 0;
    n_ce1 = 0; n_fs1 = 0; n_hs1 = 0;
    for (int i = 1; i <= 512; i++) begin
      @(posedge clk);
      #1;
      n_ce  += int'(ce0);
      n_dep += int'(ce0 && de0);
      n_hs  += int'(ce0 && hs0);
      n_vs  += int'(ce0 && vs0);
      if (fs0) begin
        n_fs++;
        if (fs_a == 0) fs_a = i;
        else fs_b = i;
      end
      if (!de0 && dout0 != 24'd0) n_bad++;
      if (!de1 && dout1 != 24'd0) n_bad++;
      n_ce1 += int'(ce1);
      n_fs1 += int'(fs1);
      n_hs1 += int'(hs1);
    end
    chk("s1_ce_count", 64'(n_ce), 64'd256);
    chk("s1_de_pixels", 64'(n_dep), 64'd64);
    chk("s1_hs_pixels", 64'(n_hs), 64'd32);
    chk("s1_vs_pixels", 64'(n_vs), 64'd32);
    chk("s1_fs_count", 64'(n_fs), 64'd2);
    chk("s1_fs_period", 64'(fs_b - fs_a), 64'd256);
    chk("s2_dout_blank", 64'(n_bad), 64'd0);
    chk("s5_ce1_const", 64'(n_ce1), 64'd512);
    chk("s5_fs1_count", 64'(n_fs1), 64'd4);
    chk("s5_hs1_count", 64'(n_hs1), 64'd64);

    wait_xy(5, 2, "s3_reach_5_2");
    enable = 1'b0;
    @(posedge clk);
    #1;
    chk("s3_off_out", 64'(g0), 64'd0);
    chk("s3_off_xy", 64'({x0, y0}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    enable = 1'b1;
    first_ce("s3");

    wait_xy(3, 1, "s4_reach_3_1");
    #3;
    chk("s4_pre_de", 64'(de0), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("s4_async_out0", 64'(g0), 64'd0);
    chk("s4_async_out1", 64'(g1), 64'd0);
    chk("s4_async_xy", 64'({x0, y0}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    first_ce("s4");

    repeat (40) @(posedge clk);
    #1;
    enable = 1'b0;
    pattern_sel = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    enable = 1'b1;
    first_ce("s6");
    px[0] = dout0;
    np = 1;
    for (int i = 0; i < 40 && np < 8; i++) begin
      @(posedge clk);
      #1;
      if (ce0) begin
        px[np] = dout0;
        np++;
      end
    end
    chk("s6_px_count", 64'(np), 64'd8);
    chk("s6_x0", 64'(px[0]), 64'(BARS ? 24'hFFFFFF : 24'h0000A5));
    chk("s6_x2", 64'(px[2]), 64'(BARS ? 24'h00FFFF : 24'h0200A5));
    chk("s6_x7", 64'(px[7]), 64'(BARS ? 24'h000000 : 24'h0700A5));
    repeat (300) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
